// File: rtl/sprite_mapper.sv
// sprite_mapper -- positioned, integer-scaled, optionally mirrored, animated
// sprite composited over a background colour on the VGA pixel path.
//
// Ports:
//   vga_clk, reset_n        pixel clock; asynchronous active-low reset
//   DrawX, DrawY, blank     current pixel coordinate and visible flag (cycle N)
//   pos_x, pos_y            sprite top-left corner on screen
//   scale                   magnification 2^scale
//   flip_x                  horizontal mirror
//   anim_en, frame_sel      internal frame sequencing / static frame select
//   bg_rgb                  background colour, aligned with DrawX
//   rom_addr, rom_q         external synchronous sprite ROM (1-cycle read)
//   pal_idx, pal_rgb        external combinational palette
//   red, green, blue, hit   registered pixel colour and opaque-texel flag (N+2)
//   cur_frame               frame currently displayed
module sprite_mapper #(
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 16,
    parameter int FRAMES     = 4,
    parameter int IDX_BITS   = 3,
    parameter int TRANSP_IDX = 0,
    parameter int ANIM_DIV   = 8,
    parameter int ADDR_W     = $clog2(FRAMES * SPRITE_W * SPRITE_H)
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic [9:0]          pos_x,
    input  logic [9:0]          pos_y,
    input  logic [1:0]          scale,
    input  logic                flip_x,
    input  logic                anim_en,
    input  logic [3:0]          frame_sel,
    input  logic [11:0]         bg_rgb,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [IDX_BITS-1:0] rom_q,
    output logic [IDX_BITS-1:0] pal_idx,
    input  logic [11:0]         pal_rgb,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                hit,
    output logic [3:0]          cur_frame
);

    localparam int LX_W = $clog2(SPRITE_W);
    localparam int LY_W = $clog2(SPRITE_H);

    // ---------------- frame sequencing ----------------
    logic [9:0]  prev_x_q, prev_y_q;
    logic        frame_start;
    logic [7:0]  div_q, div_d;
    logic [3:0]  seq_q, seq_d;
    logic [3:0]  disp_q, disp_d;
    logic [3:0]  sel_clamped;
    logic [3:0]  frame_use;

    assign frame_start = (DrawX == '0) && (DrawY == '0) &&
                         !((prev_x_q == '0) && (prev_y_q == '0));

    always_comb begin
        div_d  = div_q;
        seq_d  = seq_q;
        disp_d = disp_q;
        // 5-bit compare so FRAMES=16 does not collapse to a zero bound
        sel_clamped = ({1'b0, frame_sel} >= 5'(FRAMES)) ? 4'(FRAMES - 1) : frame_sel;
        if (frame_start) begin
            if (anim_en) begin
                if (div_q == 8'(ANIM_DIV - 1)) begin
                    div_d = '0;
                    seq_d = (seq_q == 4'(FRAMES - 1)) ? '0 : seq_q + 4'd1;
                end else begin
                    div_d = div_q + 8'd1;
                end
                disp_d = seq_d;
            end else begin
                disp_d = sel_clamped;
            end
        end
        // The pixel at (0,0) already uses the new frame, so a whole video
        // frame is drawn from a single frame source.
        frame_use = disp_d;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_x_q <= '1;
            prev_y_q <= '1;
            div_q    <= '0;
            seq_q    <= '0;
            disp_q   <= '0;
        end else begin
            prev_x_q <= DrawX;
            prev_y_q <= DrawY;
            div_q    <= div_d;
            seq_q    <= seq_d;
            disp_q   <= disp_d;
        end
    end

    assign cur_frame = disp_q;

    // ---------------- stage 0: box test and ROM address ----------------
    logic [10:0]     dx, dy, dx_sh, dy_sh;
    logic            in_box;
    logic [LX_W-1:0] lx;
    logic [LY_W-1:0] ly;

    always_comb begin
        dx    = {1'b0, DrawX} - {1'b0, pos_x};
        dy    = {1'b0, DrawY} - {1'b0, pos_y};
        dx_sh = dx >> scale;
        dy_sh = dy >> scale;
        // (d >> scale) < W is the same test as d < (W << scale); a coordinate
        // left of/above the sprite borrows into bit 10 and fails it too.
        in_box = (DrawX >= pos_x) && (DrawY >= pos_y) &&
                 (dx_sh < 11'(SPRITE_W)) && (dy_sh < 11'(SPRITE_H));
        lx = dx_sh[LX_W-1:0];
        ly = dy_sh[LY_W-1:0];
        if (flip_x) begin
            lx = LX_W'(SPRITE_W - 1) - dx_sh[LX_W-1:0];
        end
        rom_addr = ADDR_W'(32'(frame_use) * 32'(SPRITE_W * SPRITE_H)) + ADDR_W'({ly, lx});
    end

    // ---------------- stage 1: align with ROM data ----------------
    logic        in_box_q;
    logic        blank_q;
    logic [11:0] bg_q;
    logic        opaque;

    assign pal_idx = rom_q;
    assign opaque  = in_box_q && (rom_q != IDX_BITS'(TRANSP_IDX));

    // ---------------- output register ----------------
    logic [11:0] rgb_q, rgb_d;
    logic        hit_q, hit_d;

    always_comb begin
        rgb_d = '0;
        hit_d = 1'b0;
        if (blank_q) begin
            if (opaque) begin
                rgb_d = pal_rgb;
                hit_d = 1'b1;
            end else begin
                rgb_d = bg_q;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_box_q <= 1'b0;
            blank_q  <= 1'b0;
            bg_q     <= '0;
            rgb_q    <= '0;
            hit_q    <= 1'b0;
        end else begin
            in_box_q <= in_box;
            blank_q  <= blank;
            bg_q     <= bg_rgb;
            rgb_q    <= rgb_d;
            hit_q    <= hit_d;
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];
    assign hit   = hit_q;

endmodule

// File: tb/tb_sprite_mapper.sv
module tb_sprite_mapper;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        blank, flip_x, anim_en;
    logic [1:0]  scale;
    logic [3:0]  frame_sel;
    logic [11:0] bg_rgb;
    logic [9:0]  rom_addr;
    logic [2:0]  rom_q;
    logic [2:0]  pal_idx;
    logic [11:0] pal_rgb;
    logic [3:0]  red, green, blue;
    logic        hit;
    logic [3:0]  cur_frame;

    sprite_mapper #(.ANIM_DIV(2)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .flip_x(flip_x),
        .anim_en(anim_en), .frame_sel(frame_sel), .bg_rgb(bg_rgb),
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
        .red(red), .green(green), .blue(blue), .hit(hit), .cur_frame(cur_frame)
    );

    always #5 vga_clk = ~vga_clk;

    // External sync ROM: idx = (addr[3:0] + addr[9:8]) mod 8, with
    // texel 0 of frame 0 set to 5 and texel 15 of frame 0 transparent.
    logic [2:0] rom [0:1023];
    initial begin
        for (int a = 0; a < 1024; a++) begin
            logic [9:0] av;
            av = 10'(a);
            rom[a] = 3'(av[3:0] + {2'b00, av[9:8]});
        end
        rom[0]  = 3'd5;
        rom[15] = 3'd0;
    end
    always @(posedge vga_clk) rom_q <= rom[rom_addr];

    // Palette: colour of index i is 0x111*i
    assign pal_rgb = 12'(12'h111 * pal_idx);

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        hit;
        logic [11:0] rgb;
    } exp_t;
    exp_t sb[$];
    logic tag_drv = 1'b0;
    logic tag1, tag2;
    int   pix_no = 0;

    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            tag1 <= 1'b0;
            tag2 <= 1'b0;
        end else begin
            tag1 <= tag_drv;
            tag2 <= tag1;
        end
    end

    always @(negedge vga_clk) begin
        if (tag2) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("pix%0d", pix_no), {19'd0, hit, red, green, blue}, {19'd0, e});
                pix_no++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pix(input int x, input int y, input logic bl, input logic [11:0] bg,
                       input logic eh, input logic [11:0] ergb, input int eaddr);
        DrawX   = 10'(x);
        DrawY   = 10'(y);
        blank   = bl;
        bg_rgb  = bg;
        tag_drv = 1'b1;
        sb.push_back({eh, ergb});
        #1;
        if (eaddr >= 0) chk($sformatf("addr(%0d,%0d)", x, y), 32'(rom_addr), 32'(eaddr));
        @(posedge vga_clk); #1;
        tag_drv = 1'b0;
    endtask

    task automatic idle(input int x, input int y, input logic bl);
        DrawX   = 10'(x);
        DrawY   = 10'(y);
        blank   = bl;
        tag_drv = 1'b0;
        @(posedge vga_clk); #1;
    endtask

    // Leaves the bench 1 time unit into a (0,0) cycle that is a frame_start
    task automatic frame_pulse();
        idle(5, 5, 1'b0);
        DrawX = '0;
        DrawY = '0;
        #1;
    endtask

    int exp_after[9]  = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp_before[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        DrawX = 10'd5; DrawY = 10'd5; blank = 1'b0;
        pos_x = 10'd100; pos_y = 10'd50; scale = 2'd0; flip_x = 1'b0;
        anim_en = 1'b0; frame_sel = 4'd0; bg_rgb = 12'hABC;
        #3;
        chk("rst_rgb", {red, green, blue}, 12'h000);
        chk("rst_hit", hit, 1'b0);
        chk("rst_frame", cur_frame, 4'd0);
        @(posedge vga_clk); @(posedge vga_clk); #2;
        reset_n = 1'b1;
        @(posedge vga_clk); #1;

        // Position, latency, transparency inside the box
        pix(100, 50, 1, 12'hABC, 1, 12'h555, 0);
        pix( 99, 50, 1, 12'hABC, 0, 12'hABC, -1);
        pix(101, 50, 1, 12'h123, 1, 12'h111, 1);
        pix(114, 50, 1, 12'h123, 1, 12'h666, 14);
        pix(115, 50, 1, 12'h456, 0, 12'h456, 15);
        pix(116, 50, 1, 12'h789, 0, 12'h789, -1);
        pix(105, 52, 1, 12'h789, 1, 12'h555, 37);
        pix(101, 65, 1, 12'h789, 1, 12'h111, 241);
        pix(101, 66, 1, 12'hDEF, 0, 12'hDEF, -1);
        pix(101, 50, 0, 12'hABC, 0, 12'h000, 1);

        // Scale 4x with right-edge clipping
        pos_x = 10'd600; pos_y = 10'd0; scale = 2'd2;
        pix(599, 0, 1, 12'hABC, 0, 12'hABC, -1);
        pix(603, 0, 1, 12'hABC, 1, 12'h555, 0);
        pix(604, 0, 1, 12'hABC, 1, 12'h111, 1);
        pix(639, 0, 1, 12'hABC, 1, 12'h111, 9);
        pix(610, 3, 1, 12'hABC, 1, 12'h222, 2);
        pix(600, 4, 1, 12'hABC, 0, 12'hABC, 16);
        pix(604, 4, 1, 12'hABC, 1, 12'h111, 17);
        pix(  0, 0, 1, 12'h321, 0, 12'h321, -1);

        // Horizontal mirror
        pos_x = 10'd0; scale = 2'd0; flip_x = 1'b1;
        pix( 0, 0, 1, 12'hABC, 0, 12'hABC, 15);
        pix( 1, 0, 1, 12'hABC, 1, 12'h666, 14);
        pix(15, 0, 1, 12'hABC, 1, 12'h555, 0);
        pix( 3, 1, 1, 12'hABC, 1, 12'h444, 28);
        pix(16, 0, 1, 12'hABC, 0, 12'hABC, -1);

        // Static frame select with clamp; frame source changes only at frame_start
        flip_x = 1'b0; frame_sel = 4'd9;
        idle(5, 5, 1'b1);
        pix(0, 0, 1, 12'hABC, 1, 12'h333, 768);
        chk("clamp_frame", cur_frame, 4'd3);
        frame_sel = 4'd2;
        pix(2, 0, 1, 12'hABC, 1, 12'h555, 770);
        chk("no_tear_frame", cur_frame, 4'd3);
        idle(5, 5, 1'b1);
        pix(0, 0, 1, 12'hABC, 1, 12'h222, 512);
        chk("sel2_frame", cur_frame, 4'd2);

        // Reset asserted mid-sprite, then resume
        pos_x = 10'd100; pos_y = 10'd50;
        idle(101, 50, 1'b1);
        idle(101, 50, 1'b1);
        chk("pre_rst_hit", hit, 1'b1);
        chk("pre_rst_rgb", {red, green, blue}, 12'h333);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_rgb", {red, green, blue}, 12'h000);
        chk("mid_rst_hit", hit, 1'b0);
        chk("mid_rst_frame", cur_frame, 4'd0);
        @(posedge vga_clk); @(posedge vga_clk); #1;
        reset_n = 1'b1;
        pix(101, 50, 1, 12'hABC, 1, 12'h111, 1);
        chk("rst_gap_hit", hit, 1'b0);
        pix(102, 50, 1, 12'hABC, 1, 12'h222, 2);
        idle(5, 5, 1'b0);
        idle(5, 5, 1'b0);

        // Animation: reset while sitting on (0,0) so the first cycle after
        // release is itself a frame_start
        pos_x = 10'd0; pos_y = 10'd0; anim_en = 1'b1; frame_sel = 4'd0;
        DrawX = '0; DrawY = '0; blank = 1'b0;
        #1 reset_n = 1'b0;
        @(posedge vga_clk); @(posedge vga_clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) frame_pulse();
            else #1;
            chk($sformatf("anim_cur%0d", k + 1), cur_frame, 32'(exp_before[k]));
            chk($sformatf("anim_addr%0d", k + 1), rom_addr, 32'(exp_after[k] * 256));
            @(posedge vga_clk); #1;
            @(posedge vga_clk); #1;
        end

        // Hold while anim_en=0, resume from held sequencer value
        anim_en = 1'b0; frame_sel = 4'd3;
        frame_pulse();
        @(posedge vga_clk); #1;
        chk("hold_frame", cur_frame, 4'd3);
        frame_pulse();
        @(posedge vga_clk); #1;
        anim_en = 1'b1;
        frame_pulse();
        chk("resume_addr", rom_addr, 10'd256);
        @(posedge vga_clk); #1;
        chk("resume_frame", cur_frame, 4'd1);

        repeat (4) @(posedge vga_clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_mapper.md
# sprite_mapper

Parametrised sprite renderer for the VGA pixel path: it replaces the fixed full-screen 16x16 image mapper with a positioned, integer-scaled, optionally mirrored, multi-frame animated sprite with a transparent colour key. The sprite is composited over a background colour. It sits between the VGA controller (DrawX/DrawY/blank) and the colour-output mux. Sprite ROM and palette stay external so one mapper serves any sprite asset.

## Interface
- SPRITE_W, 16, sprite width in texels; power of two.
- SPRITE_H, 16, sprite height in texels; power of two.
- FRAMES, 4, animation frames stored back-to-back in ROM; 1..16.
- IDX_BITS, 3, palette index width.
- TRANSP_IDX, 0, palette index treated as transparent.
- ANIM_DIV, 8, video frames per animation step; 1..255.
- ADDR_W, $clog2(FRAMES*SPRITE_W*SPRITE_H), ROM address width (derived).
- vga_clk  in  1  pixel clock; the block's only clock.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- blank  in  1  1 = visible pixel, 0 = blanking.
- pos_x, pos_y  in  10 each  screen position of the sprite's top-left corner.
- scale  in  2  magnification 2^scale (1x, 2x, 4x, 8x).
- flip_x  in  1  mirror horizontally.
- anim_en  in  1  1 = internal frame sequencing, 0 = use frame_sel.
- frame_sel  in  4  static frame when anim_en=0; values >= FRAMES are clamped to FRAMES-1.
- bg_rgb  in  12  background colour {r,g,b}, aligned with DrawX.
- rom_addr  out  ADDR_W  combinational address to the external sync ROM.
- rom_q  in  IDX_BITS  ROM data, one cycle after rom_addr.
- pal_idx  out  IDX_BITS  equals rom_q; drives the external combinational palette.
- pal_rgb  in  12  palette colour for pal_idx.
- red, green, blue  out  4 each  registered pixel colour.
- hit  out  1  registered; 1 = an opaque sprite texel was drawn this pixel.
- cur_frame  out  4  frame currently displayed.

## Operation
- Stage 0 (combinational on cycle N inputs):
  - dx = {1'b0,DrawX} - {1'b0,pos_x}, 11-bit; dy likewise.
  - in_box = (DrawX >= pos_x) && (dx < SPRITE_W<<scale) && the same test for Y.
  - The sprite is clipped at screen right/bottom. It never wraps to x/y = 0.
  - lx = dx>>scale, ly = dy>>scale. If flip_x, lx = SPRITE_W-1-lx.
  - rom_addr = frame*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx, computed from the truncated lx/ly.
  - rom_addr is don't-care when in_box=0.
- Stage 1 (cycle N+1):
  - in_box, blank and bg_rgb from cycle N are held in registers, aligned with rom_q.
  - opaque = in_box_d && (rom_q != TRANSP_IDX).
- Output register (edge ending cycle N+1):
  - blank_d=0: RGB = 0, hit = 0.
  - Otherwise, opaque: RGB = pal_rgb, hit = 1.
  - Otherwise: RGB = bg_rgb_d, hit = 0.
- Animation:
  - frame_start is a one-cycle pulse when (DrawX,DrawY) = (0,0) and the previous cycle's coordinate was not (0,0).
  - An 8-bit divider counts frame_starts. When it reaches ANIM_DIV-1 it returns to 0 and cur_frame advances.
  - cur_frame wraps FRAMES-1 -> 0.
  - Divider and sequencer run only while anim_en=1. While anim_en=0 they hold.
- Frame selection:
  - anim_en=0: the frame used = clamped frame_sel; cur_frame outputs that value.
  - On the 0->1 edge of anim_en, the sequence resumes from the held sequencer value.
- Frame source updates only at frame_start, so a sprite never tears mid-frame. pos_x, pos_y and scale are sampled every cycle; the caller changes them during vertical blank.

## Timing
- Latency: DrawX/DrawY/blank/bg_rgb at cycle N -> red/green/blue/hit valid after the 2nd rising edge (cycle N+2). This matches the previous mapper, so the output mux needs no realignment.
- Throughput: one pixel per clock, with no stalls.
- Reset (asynchronous assert, synchronous-safe release): red/green/blue = 0, hit = 0, cur_frame = 0, divider = 0, pipeline valid/blank registers = 0, previous-coordinate register = 0x3FF/0x3FF. With that register value, the first (0,0) after reset produces frame_start.
- Reset asserted mid-line: outputs go to 0 immediately. The first valid pixel after release appears 2 cycles later.
- Simultaneous frame_start with the divider at ANIM_DIV-1 and cur_frame at FRAMES-1: cur_frame becomes 0 and the divider becomes 0 in the same cycle.

## Test plan
- Position and latency: pos=(100,50), scale=0, ROM texel (0,0) = idx 5. DrawX=100, DrawY=50 at cycle N -> hit=1 and RGB=palette[5] at N+2. DrawX=99 -> hit=0 and RGB=bg_rgb.
- Scale and clip: scale=2, pos=(600,0), SPRITE_W=16, so the extent is 64 px. DrawX=603 reads texel lx=0. DrawX=604 reads lx=1. DrawX=639 reads lx=9, and nothing is drawn past the screen edge. DrawX=0 gives hit=0, confirming no wrap.
- Flip and transparency: flip_x=1, pos=(0,0), scale=0. DrawX=0 addresses texel lx=15. A texel with idx 0 gives hit=0 and RGB=bg_rgb=0xABC.
- Animation: anim_en=1, ANIM_DIV=2, FRAMES=4. Over 8 frame_starts, cur_frame steps 0,0,1,1,2,2,3,3, then wraps to 0 on the 9th.
- Static select and clamp: anim_en=0, frame_sel=9 with FRAMES=4 -> cur_frame=3 and rom_addr base = 768.
- Blanking and reset: blank=0 inside the box -> RGB=0 and hit=0. Assert reset_n=0 mid-sprite -> RGB/hit/cur_frame = 0 in the same cycle. Release -> correct pixels resume 2 cycles later.
